ctrl_seq_unit: RTL and testbench

Registered, parametrised successor to the combinational control unit. Accepts one opcode per cycle from fetch through a valid/ready handshake and holds decoded controls in an execute (EX) register. It keeps an architectural flag register (zf/sf/cf) with forwarding from the ALU, and stalls fetch for multi-cycle multiplies and taken jumps. It sits between instruction fetch and the ALU/register-file write port.

---
 rtl/ctrl_seq_unit.sv | 210 +++++++++++++++++++++
 tb/tb_ctrl_seq_unit.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_seq_unit.sv
// Registered control unit: decodes one opcode per cycle into an EX register,
// keeps the architectural flags, and stalls fetch for multiplies and taken jumps.
module ctrl_seq_unit #(
   parameter int unsigned OP_W      = 6,
   parameter int unsigned MUL_LAT   = 3,
   parameter int unsigned FLAG_MODE = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            op_valid,
   input  logic [OP_W-1:0] op,
   output logic            op_ready,
   input  logic            zf_in,
   input  logic            sf_in,
   input  logic            cf_in,
   output logic            ex_valid,
   output logic [3:0]      alu_op,
   output logic            imm_select,
   output logic            wreg,
   output logic            jmp_select,
   output logic            illegal,
   output logic            zf,
   output logic            sf,
   output logic            cf
);

   localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam int unsigned ALU_W = 4;

   typedef enum logic {
      ST_RUN = 1'b0,
      ST_MUL = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ex_valid_q, ex_valid_d;
   logic [ALU_W-1:0]   alu_q, alu_d;
   logic               imm_q, imm_d;
   logic               wreg_q, wreg_d;
   logic               jmp_q, jmp_d;
   logic               ill_q, ill_d;
   logic               wr_q, wr_d;
   logic               fset_q, fset_d;
   logic [2:0]         flags_q, flags_d;

   logic [ALU_W-1:0]   dec_alu;
   logic               dec_imm, dec_wr, dec_fset, dec_mul, dec_jmp, dec_ill;
   logic               op_hi_nz;
   logic               fwd;
   logic [2:0]         flags_in, eff;
   logic               accept;

   // Condition for jump selector c given flags f = {zf, sf, cf}.
   function automatic logic jmp_cond(input logic [3:0] c, input logic [2:0] f);
      logic z, s, cy;
      z  = f[2];
      s  = f[1];
      cy = f[0];
      case (c)
         4'd0:    jmp_cond = 1'b1;
         4'd1:    jmp_cond = z;
         4'd2:    jmp_cond = ~z;
         4'd3:    jmp_cond = s & ~z;
         4'd4:    jmp_cond = s | z;
         4'd5:    jmp_cond = ~s & ~z;
         4'd6:    jmp_cond = ~s | z;
         4'd7:    jmp_cond = cy;
         4'd8:    jmp_cond = ~cy;
         4'd9:    jmp_cond = z;
         4'd10:   jmp_cond = ~z;
         default: jmp_cond = 1'b0;
      endcase
   endfunction

   // Opcode decode of the incoming fetch word.
   always_comb begin
      dec_alu  = '0;
      dec_imm  = 1'b0;
      dec_wr   = 1'b0;
      dec_fset = 1'b0;
      dec_mul  = 1'b0;
      dec_jmp  = 1'b0;
      dec_ill  = 1'b0;
      op_hi_nz = (op >> 6) != '0;
      if (op_hi_nz) begin
         dec_ill = 1'b1;
      end else if (!op[5] && (op[3:0] <= 4'd9)) begin
         dec_imm  = op[4];
         dec_wr   = (op[3:0] != 4'd9);
         dec_fset = (FLAG_MODE != 0) || (op[3:0] == 4'd9);
         dec_mul  = (op[3:0] == 4'd2);
         case (op[3:0])
            4'd0:    dec_alu = 4'b0000;
            4'd1:    dec_alu = 4'b0100;
            4'd2:    dec_alu = 4'b0001;
            4'd3:    dec_alu = 4'b0010;
            4'd4:    dec_alu = 4'b0110;
            4'd5:    dec_alu = 4'b1010;
            4'd6:    dec_alu = 4'b0011;
            4'd7:    dec_alu = 4'b0111;
            4'd8:    dec_alu = 4'b1011;
            4'd9:    dec_alu = 4'b0100;
            default: dec_alu = 4'b0000;
         endcase
      end else if ((op[5:4] == 2'b11) && (op[3:0] <= 4'd10)) begin
         dec_jmp = 1'b1;
      end else begin
         dec_ill = 1'b1;
      end
   end

   // Next-state, handshake and flag forwarding.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ex_valid_d = ex_valid_q;
      alu_d      = alu_q;
      imm_d      = imm_q;
      wr_d       = wr_q;
      fset_d     = fset_q;
      ill_d      = ill_q;
      jmp_d      = 1'b0;
      wreg_d     = 1'b0;
      flags_d    = flags_q;

      fwd      = ex_valid_q & fset_q & (state_q == ST_RUN);
      flags_in = {zf_in, sf_in, cf_in};
      eff      = fwd ? flags_in : flags_q;
      if (fwd) flags_d = flags_in;

      op_ready = (state_q == ST_RUN) & ~(ex_valid_q & jmp_q);
      accept   = op_valid & op_ready;

      case (state_q)
         ST_RUN: begin
            if (accept) begin
               ex_valid_d = 1'b1;
               alu_d      = dec_alu;
               imm_d      = dec_imm;
               wr_d       = dec_wr;
               fset_d     = dec_fset;
               ill_d      = dec_ill;
               jmp_d      = dec_jmp & jmp_cond(op[3:0], eff);
               if (dec_mul && (MUL_LAT > 1)) begin
                  state_d = ST_MUL;
                  cnt_d   = CNT_W'(MUL_LAT - 1);
               end else begin
                  wreg_d = dec_wr;
               end
            end else begin
               ex_valid_d = 1'b0;
               alu_d      = '0;
               imm_d      = 1'b0;
               wr_d       = 1'b0;
               fset_d     = 1'b0;
               ill_d      = 1'b0;
            end
         end
         ST_MUL: begin
            cnt_d = cnt_q - 1'b1;
            // Counter at 1: the coming cycle is the multiply's final EX cycle.
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_RUN;
               wreg_d  = wr_q;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_RUN;
         cnt_q      <= '0;
         ex_valid_q <= 1'b0;
         alu_q      <= '0;
         imm_q      <= 1'b0;
         wreg_q     <= 1'b0;
         jmp_q      <= 1'b0;
         ill_q      <= 1'b0;
         wr_q       <= 1'b0;
         fset_q     <= 1'b0;
         flags_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ex_valid_q <= ex_valid_d;
         alu_q      <= alu_d;
         imm_q      <= imm_d;
         wreg_q     <= wreg_d;
         jmp_q      <= jmp_d;
         ill_q      <= ill_d;
         wr_q       <= wr_d;
         fset_q     <= fset_d;
         flags_q    <= flags_d;
      end
   end

   assign ex_valid   = ex_valid_q;
   assign alu_op     = alu_q;
   assign imm_select = imm_q;
   assign wreg       = wreg_q;
   assign jmp_select = jmp_q;
   assign illegal    = ill_q;
   assign zf         = flags_q[2];
   assign sf         = flags_q[1];
   assign cf         = flags_q[0];

endmodule

// File: tb/tb_ctrl_seq_unit.sv
// Bench for ctrl_seq_unit: two configurations driven side by side and checked
// every cycle against an instruction-occupancy model, plus directed scenarios.
module tb_ctrl_seq_unit;

   localparam int unsigned LAT0 = 3;
   localparam int unsigned LAT1 = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       zf_in = 1'b0, sf_in = 1'b0, cf_in = 1'b0;
   logic [1:0] op_valid_w = '0;
   logic [7:0] op_w [2];
   logic [1:0] op_ready_w, ex_valid_w, imm_w, wreg_w, jmp_w, ill_w, zf_w, sf_w, cf_w;
   logic [3:0] alu_w [2];

   ctrl_seq_unit #(.OP_W(6), .MUL_LAT(LAT0), .FLAG_MODE(0)) u_dut0 (
      .clk(clk), .rst(rst), .op_valid(op_valid_w[0]), .op(op_w[0][5:0]),
      .op_ready(op_ready_w[0]), .zf_in(zf_in), .sf_in(sf_in), .cf_in(cf_in),
      .ex_valid(ex_valid_w[0]), .alu_op(alu_w[0]), .imm_select(imm_w[0]),
      .wreg(wreg_w[0]), .jmp_select(jmp_w[0]), .illegal(ill_w[0]),
      .zf(zf_w[0]), .sf(sf_w[0]), .cf(cf_w[0]));

   ctrl_seq_unit #(.OP_W(8), .MUL_LAT(LAT1), .FLAG_MODE(1)) u_dut1 (
      .clk(clk), .rst(rst), .op_valid(op_valid_w[1]), .op(op_w[1]),
      .op_ready(op_ready_w[1]), .zf_in(zf_in), .sf_in(sf_in), .cf_in(cf_in),
      .ex_valid(ex_valid_w[1]), .alu_op(alu_w[1]), .imm_select(imm_w[1]),
      .wreg(wreg_w[1]), .jmp_select(jmp_w[1]), .illegal(ill_w[1]),
      .zf(zf_w[1]), .sf(sf_w[1]), .cf(cf_w[1]));

   always #5 clk = ~clk;

   // Model: the instruction in EX, which of its EX cycles this is, and how many it has.
   typedef struct packed {
      logic       valid;
      logic [3:0] alu;
      logic       imm;
      logic       writes;
      logic       fset;
      logic       jt;
      logic       ill;
      logic [3:0] age;
      logic [3:0] len;
   } ex_t;

   ex_t        m_ex [2];
   logic [2:0] m_fl [2];
   logic [1:0] acc = '0;
   int         lat_k [2] = '{3, 4};
   int         fm_k  [2] = '{0, 1};
   logic [3:0] alu_tab [10] = '{4'h0, 4'h4, 4'h1, 4'h2, 4'h6, 4'hA, 4'h3, 4'h7, 4'hB, 4'h4};
   int         total = 0;
   int         bad = 0;

   task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s lane%0d got=%0h want=%0h @%0t", name, k, act, exp, $time);
      end
   endtask

   function automatic logic model_ready(input int k);
      return !(m_ex[k].valid && ((m_ex[k].age < m_ex[k].len) || m_ex[k].jt));
   endfunction

   function automatic logic jcond(input logic [3:0] n, input logic [2:0] f);
      logic z, s, c;
      z = f[2]; s = f[1]; c = f[0];
      case (n)
         4'd0:         return 1'b1;
         4'd1, 4'd9:   return z;
         4'd2, 4'd10:  return !z;
         4'd3:         return s && !z;
         4'd4:         return s || z;
         4'd5:         return !s && !z;
         4'd6:         return !s || z;
         4'd7:         return c;
         default:      return !c;
      endcase
   endfunction

   function automatic ex_t decode(input int k, input logic [7:0] o, input logic [2:0] f);
      ex_t        d;
      logic [3:0] nib;
      logic [1:0] grp;
      logic       up;
      d     = '0;
      nib   = o[3:0];
      grp   = o[5:4];
      up    = (k == 1) && (o[7:6] != 2'b00);
      d.valid = 1'b1;
      d.age   = 4'd1;
      d.len   = 4'd1;
      if (up) d.ill = 1'b1;
      else if ((grp == 2'b00 || grp == 2'b01) && nib <= 4'd9) begin
         d.alu    = alu_tab[nib];
         d.imm    = (grp == 2'b01);
         d.writes = (nib != 4'd9);
         d.fset   = (fm_k[k] == 1) || (nib == 4'd9);
         if (nib == 4'd2) d.len = 4'(lat_k[k]);
      end else if (grp == 2'b11 && nib <= 4'd10) d.jt = jcond(nib, f);
      else d.ill = 1'b1;
      return d;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_ex[k] = '0;
         m_fl[k] = '0;
      end
   endtask

   task automatic advance(input int k);
      logic [2:0] inf, f;
      logic       fwd;
      inf = {zf_in, sf_in, cf_in};
      fwd = m_ex[k].valid && (m_ex[k].age == m_ex[k].len) && m_ex[k].fset;
      f   = fwd ? inf : m_fl[k];
      if (fwd) m_fl[k] = inf;
      if (m_ex[k].valid && (m_ex[k].age < m_ex[k].len)) m_ex[k].age = m_ex[k].age + 4'd1;
      else if (acc[k]) m_ex[k] = decode(k, op_w[k], f);
      else m_ex[k] = '0;
   endtask

   task automatic compare(input int k);
      ex_t m;
      m = m_ex[k];
      chk("op_ready", k, 8'(op_ready_w[k]), 8'(model_ready(k)));
      chk("ex_valid", k, 8'(ex_valid_w[k]), 8'(m.valid));
      chk("wreg", k, 8'(wreg_w[k]), 8'(m.valid && m.writes && (m.age == m.len)));
      chk("jmp_select", k, 8'(jmp_w[k]), 8'(m.valid && m.jt));
      chk("illegal", k, 8'(ill_w[k]), 8'(m.valid && m.ill));
      chk("flags", k, 8'({zf_w[k], sf_w[k], cf_w[k]}), 8'(m_fl[k]));
      if (m.valid) begin
         chk("alu_op", k, 8'(alu_w[k]), 8'(m.alu));
         chk("imm_select", k, 8'(imm_w[k]), 8'(m.imm));
      end
   endtask

   // One clock: check at the falling edge, step the model, land 1 time unit past the rising edge.
   task automatic tick();
      @(negedge clk);
      for (int k = 0; k < 2; k++) compare(k);
      for (int k = 0; k < 2; k++) begin
         acc[k] = op_valid_w[k] && model_ready(k);
         if (rst) begin
            m_ex[k] = '0;
            m_fl[k] = '0;
         end else advance(k);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int k, input logic [7:0] opc, output int n);
      op_valid_w[k] = 1'b1;
      op_w[k]       = opc;
      n = 0;
      do begin
         tick();
         n++;
      end while (!acc[k] && n < 20);
      if (!acc[k]) begin
         bad++;
         total++;
         $display("FAIL accept_timeout lane%0d op=%0h got=not_accepted want=accepted", k, opc);
      end
   endtask

   task automatic do_reset();
      op_valid_w = '0;
      rst = 1'b1;
      #1;
      model_reset();
      for (int k = 0; k < 2; k++) begin
         chk("rst_ex_valid", k, 8'(ex_valid_w[k]), 8'h0);
         chk("rst_alu_op", k, 8'(alu_w[k]), 8'h0);
         chk("rst_wreg", k, 8'(wreg_w[k]), 8'h0);
         chk("rst_jmp", k, 8'(jmp_w[k]), 8'h0);
         chk("rst_flags", k, 8'({zf_w[k], sf_w[k], cf_w[k], imm_w[k], ill_w[k]}), 8'h0);
      end
      tick();
      rst = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) chk("post_rst_ready", k, 8'(op_ready_w[k]), 8'h1);
   endtask

   function automatic logic [7:0] rand_op(input int k);
      int r;
      r = $urandom_range(0, 15);
      if (r < 7)       return 8'(($urandom_range(0, 1) << 4) | $urandom_range(0, 9));
      else if (r < 9)  return ($urandom_range(0, 1) != 0) ? 8'h02 : 8'h12;
      else if (r < 13) return 8'(32'h30 | $urandom_range(0, 10));
      else if (r < 15) return 8'($urandom_range(0, 63));
      else             return (k == 1) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 63));
   endfunction

   initial begin
      int n;
      op_w[0] = '0;
      op_w[1] = '0;
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // cmp with zf_in=1: no register write, zf set after its EX cycle.
      zf_in = 1'b1; sf_in = 1'b0; cf_in = 1'b0;
      send(0, 8'h09, n);
      chk("cmp_wreg", 0, 8'(wreg_w[0]), 8'h0);
      op_valid_w[0] = 1'b0;
      tick();
      chk("cmp_zf", 0, 8'(zf_w[0]), 8'h1);

      // Back-to-back add, subi, or, sra.
      send(0, 8'h00, n);
      chk("s_add_alu", 0, 8'(alu_w[0]), 8'h0);
      chk("s_add_wreg", 0, 8'(wreg_w[0]), 8'h1);
      send(0, 8'h11, n);
      chk("s_subi_lat", 0, 8'(n), 8'h1);
      chk("s_subi_alu", 0, 8'(alu_w[0]), 8'h4);
      chk("s_subi_imm", 0, 8'(imm_w[0]), 8'h1);
      send(0, 8'h04, n);
      chk("s_or_alu", 0, 8'(alu_w[0]), 8'h6);
      chk("s_or_imm", 0, 8'(imm_w[0]), 8'h0);
      send(0, 8'h08, n);
      chk("s_sra_alu", 0, 8'(alu_w[0]), 8'hB);
      chk("s_sra_wreg", 0, 8'(wreg_w[0]), 8'h1);
      op_valid_w[0] = 1'b0;
      tick();

      // mul (3 cycles) then add.
      send(0, 8'h02, n);
      chk("mul1_ready", 0, 8'(op_ready_w[0]), 8'h0);
      chk("mul1_wreg", 0, 8'(wreg_w[0]), 8'h0);
      chk("mul1_alu", 0, 8'(alu_w[0]), 8'h1);
      op_w[0] = 8'h00;
      tick();
      chk("mul2_ready", 0, 8'(op_ready_w[0]), 8'h0);
      chk("mul2_wreg", 0, 8'(wreg_w[0]), 8'h0);
      tick();
      chk("mul3_ready", 0, 8'(op_ready_w[0]), 8'h1);
      chk("mul3_wreg", 0, 8'(wreg_w[0]), 8'h1);
      chk("mul3_alu", 0, 8'(alu_w[0]), 8'h1);
      tick();
      chk("add_after_mul_acc", 0, 8'(acc[0]), 8'h1);
      chk("add_after_mul_alu", 0, 8'(alu_w[0]), 8'h0);
      op_valid_w[0] = 1'b0;
      tick();

      // cmp (zf=0, sf=1) then jl: taken with a one-cycle bubble.
      zf_in = 1'b0; sf_in = 1'b1; cf_in = 1'b0;
      send(0, 8'h09, n);
      send(0, 8'h33, n);
      chk("jl_lat", 0, 8'(n), 8'h1);
      chk("jl_taken", 0, 8'(jmp_w[0]), 8'h1);
      chk("jl_ready", 0, 8'(op_ready_w[0]), 8'h0);
      op_w[0] = 8'h00;
      tick();
      chk("jl_bubble", 0, 8'({ex_valid_w[0], jmp_w[0]}), 8'h0);
      tick();
      chk("jl_next_acc", 0, 8'(acc[0]), 8'h1);
      send(0, 8'h09, n);
      send(0, 8'h36, n);
      chk("jge_not_taken", 0, 8'(jmp_w[0]), 8'h0);
      chk("jge_ready", 0, 8'(op_ready_w[0]), 8'h1);

      // Illegal opcode 0x2A: no write, no flag change, no bubble.
      zf_in = 1'b1; sf_in = 1'b0; cf_in = 1'b1;
      send(0, 8'h2A, n);
      chk("ill_flag", 0, 8'(ill_w[0]), 8'h1);
      chk("ill_wreg", 0, 8'(wreg_w[0]), 8'h0);
      send(0, 8'h00, n);
      chk("ill_next_lat", 0, 8'(n), 8'h1);
      chk("ill_next_ill", 0, 8'(ill_w[0]), 8'h0);
      op_valid_w[0] = 1'b0;
      tick();
      chk("ill_flags_held", 0, 8'({zf_w[0], sf_w[0], cf_w[0]}), 8'h2);

      // add (zf_in=1) then jz under both flag modes.
      do_reset();
      zf_in = 1'b1; sf_in = 1'b0; cf_in = 1'b0;
      send(0, 8'h00, n);
      send(0, 8'h39, n);
      chk("fm0_jz", 0, 8'(jmp_w[0]), 8'h0);
      op_valid_w[0] = 1'b0;
      tick();
      send(1, 8'h00, n);
      send(1, 8'h39, n);
      chk("fm1_jz", 1, 8'(jmp_w[1]), 8'h1);
      op_valid_w[1] = 1'b0;
      tick();
      tick();

      // Reset in the middle of a multiply.
      send(1, 8'h12, n);
      tick();
      do_reset();

      for (int i = 0; i < 3000; i++) begin
         for (int k = 0; k < 2; k++) begin
            if (!op_valid_w[k] || acc[k]) begin
               op_valid_w[k] = ($urandom_range(0, 7) != 0);
               op_w[k]       = rand_op(k);
            end
         end
         zf_in = 1'($urandom_range(0, 1));
         sf_in = 1'($urandom_range(0, 1));
         cf_in = 1'($urandom_range(0, 1));
         if (i == 1500) do_reset();
         else tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

endmodule
